retran_sched: RTL and testbench

RETRAN_SCHED -- requirements
Module: retran_sched

---
 rtl/retran_sched_pkg.sv | 15 +
 rtl/retran_flow_timer.sv | 89 ++++++++
 rtl/retran_sched.sv | 87 ++++++++
 tb/tb_retran_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/retran_sched_pkg.sv
// Shared types and widths for the retransmit scheduler.
package retran_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND_NEW,
      ST_IN_FLIGHT,
      ST_PEND_RETRY
   } flow_state_e;

   localparam int BACKOFF_CAP = 4;
   localparam int TIMER_W     = 8;
   localparam int RETRY_W     = 4;

endpackage

// File: rtl/retran_flow_timer.sv
// Per-flow state machine: pending/in-flight tracking, backoff timer, retry count.
module retran_flow_timer
   import retran_sched_pkg::*;
#(
   parameter int BASIC_TIME = 15,
   parameter int MAX_RETRY  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        ack,
   input  logic        grant,
   output flow_state_e state,
   output logic        fail
);

   flow_state_e        state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d, load;
   logic [RETRY_W-1:0] retry_q, retry_d, bidx;
   logic               fail_q, fail_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         retry_q <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         fail_q  <= fail_d;
      end
   end

   // Backoff grows linearly with retries, then saturates at the cap.
   always_comb begin
      bidx = (retry_q > RETRY_W'(BACKOFF_CAP)) ?
             RETRY_W'(BACKOFF_CAP) : retry_q;
      load = TIMER_W'((int'(bidx) + 1) * BASIC_TIME);
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      retry_d = retry_q;
      fail_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_PEND_NEW;
               retry_d = '0;
            end
         end
         ST_PEND_NEW: begin
            if (grant) begin
               state_d = ST_IN_FLIGHT;
               timer_d = load;
            end
         end
         ST_PEND_RETRY: begin
            if (ack) begin
               state_d = ST_IDLE;
            end else if (grant) begin
               state_d = ST_IN_FLIGHT;
               timer_d = load;
            end
         end
         ST_IN_FLIGHT: begin
            if (ack) begin
               state_d = ST_IDLE;
            end else if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
               state_d = ST_PEND_RETRY;
               retry_d = retry_q + 1'b1;
            end else begin
               state_d = ST_IDLE;
               fail_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign state = state_q;
   assign fail  = fail_q;

endmodule

// File: rtl/retran_sched.sv
// Retransmit scheduler: N flows share one transmit port, retries beat new sends.
module retran_sched
   import retran_sched_pkg::*;
#(
   parameter int N_FLOWS    = 4,
   parameter int BASIC_TIME = 15,
   parameter int MAX_RETRY  = 8,
   localparam int FW = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_FLOWS-1:0] req,
   input  logic [N_FLOWS-1:0] ack,
   input  logic               tx_ready,
   output logic               send_valid,
   output logic [FW-1:0]      send_flow,
   output logic               send_retry,
   output logic [N_FLOWS-1:0] busy,
   output logic [N_FLOWS-1:0] fail
);

   flow_state_e        st [N_FLOWS];
   logic [N_FLOWS-1:0] pr, pn, cand, gnt;
   logic [FW-1:0]      ptr, gid;
   logic               found, go;

   function automatic int wrap(input int v);
      return (v >= N_FLOWS) ? v - N_FLOWS : v;
   endfunction

   for (genvar g = 0; g < N_FLOWS; g++) begin : g_flow
      retran_flow_timer #(
         .BASIC_TIME(BASIC_TIME),
         .MAX_RETRY (MAX_RETRY)
      ) u_flow (
         .clk  (clk),
         .rst  (rst),
         .req  (req[g]),
         .ack  (ack[g]),
         .grant(gnt[g]),
         .state(st[g]),
         .fail (fail[g])
      );
   end

   // An ack on a pending retry cancels it, so it must not win arbitration.
   always_comb begin
      pr   = '0;
      pn   = '0;
      busy = '0;
      for (int i = 0; i < N_FLOWS; i++) begin
         pr[i]   = (st[i] == ST_PEND_RETRY) && !ack[i];
         pn[i]   = (st[i] == ST_PEND_NEW);
         busy[i] = (st[i] != ST_IDLE);
      end
      cand = (|pr) ? pr : pn;
   end

   always_comb begin
      found = 1'b0;
      gid   = '0;
      for (int k = 0; k < N_FLOWS; k++) begin
         if (!found && cand[FW'(wrap(int'(ptr) + k))]) begin
            found = 1'b1;
            gid   = FW'(wrap(int'(ptr) + k));
         end
      end
      go  = found && tx_ready;
      gnt = '0;
      if (go) gnt[gid] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         send_valid <= 1'b0;
         send_flow  <= '0;
         send_retry <= 1'b0;
         ptr        <= '0;
      end else begin
         send_valid <= go;
         send_flow  <= go ? gid : '0;
         send_retry <= go && (|pr);
         if (go) ptr <= (int'(gid) == N_FLOWS - 1) ? '0 : gid + 1'b1;
      end
   end

endmodule

// File: tb/tb_retran_sched.sv
// Directed bench for retran_sched with hand-computed expectations.
module tb_retran_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_ready;
   logic [3:0] req, ack, busy, fail;
   logic       send_valid, send_retry;
   logic [1:0] send_flow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   retran_sched #(
      .N_FLOWS   (4),
      .BASIC_TIME(15),
      .MAX_RETRY (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .ack       (ack),
      .tx_ready  (tx_ready),
      .send_valid(send_valid),
      .send_flow (send_flow),
      .send_retry(send_retry),
      .busy      (busy),
      .fail      (fail)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts idle cycles up to the next send; gives up after 300.
   task automatic wait_send(output int idle);
      idle = 0;
      step();
      while (!send_valid && idle < 300) begin
         idle++;
         step();
      end
      if (!send_valid) check("send_timeout", 0, 1);
   endtask

   task automatic check_send(input string tag, input int flow, input int retry);
      check({tag, "_valid"}, int'(send_valid), 1);
      check({tag, "_flow"}, int'(send_flow), flow);
      check({tag, "_retry"}, int'(send_retry), retry);
   endtask

   int gaps [8] = '{16, 31, 46, 61, 76, 76, 76, 76};
   int g, k, saw_send, saw_fail;

   initial begin
      rst = 1'b0;
      req = '0;
      ack = '0;
      tx_ready = 1'b1;
      repeat (3) step();
      check("rst_valid", int'(send_valid), 0);
      check("rst_flow", int'(send_flow), 0);
      check("rst_retry", int'(send_retry), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_fail", int'(fail), 0);

      // Single flow: first send, backoff ladder, then abandon.
      rst = 1'b1;
      req = 4'b0001;
      step();
      check("a_busy", int'(busy), int'(4'b0001));
      check("a_nosend", int'(send_valid), 0);
      step();
      check_send("a_first", 0, 0);
      req = '0;
      for (int r = 0; r < 8; r++) begin
         wait_send(g);
         check($sformatf("a_gap%0d", r), g, gaps[r]);
         check($sformatf("a_retry%0d", r), int'(send_retry), 1);
      end
      k = 0;
      saw_send = 0;
      do begin
         step();
         k++;
         if (send_valid) saw_send = 1;
      end while (!fail[0] && k < 300);
      check("a_fail_lat", k, 76);
      check("a_fail_vec", int'(fail), int'(4'b0001));
      check("a_fail_nosend", saw_send, 0);
      check("a_fail_busy", int'(busy), 0);
      step();
      check("a_fail_pulse", int'(fail), 0);

      // Two new flows together, then pointer sits after flow 2.
      req = 4'b0110;
      step();
      check("b_nosend", int'(send_valid), 0);
      step();
      check_send("b_s1", 1, 0);
      step();
      check_send("b_s2", 2, 0);
      req = '0;
      ack = 4'b0110;
      step();
      ack = '0;
      check("b_busy", int'(busy), 0);
      req = 4'b1010;
      step();
      step();
      check_send("b_rr3", 3, 0);
      step();
      check_send("b_rr1", 1, 0);
      req = '0;
      ack = 4'b1010;
      step();
      ack = '0;
      check("b_busy2", int'(busy), 0);

      // Retry from flow 3 beats a new packet on flow 0.
      req = 4'b1000;
      step();
      step();
      check_send("c_init", 3, 0);
      req = '0;
      repeat (15) step();
      req = 4'b0001;
      step();
      req = '0;
      check("c_nosend", int'(send_valid), 0);
      check("c_busy", int'(busy), int'(4'b1001));
      step();
      check_send("c_retry", 3, 1);
      step();
      check_send("c_new", 0, 0);
      ack = 4'b1001;
      step();
      ack = '0;
      check("c_busy2", int'(busy), 0);

      // Ack on the very cycle the timer reaches zero.
      req = 4'b0001;
      step();
      step();
      check_send("d_init", 0, 0);
      req = '0;
      repeat (15) step();
      ack = 4'b0001;
      step();
      ack = '0;
      check("d_busy", int'(busy), 0);
      saw_send = 0;
      saw_fail = 0;
      repeat (40) begin
         step();
         if (send_valid) saw_send = 1;
         if (|fail) saw_fail = 1;
      end
      check("d_nosend", saw_send, 0);
      check("d_nofail", saw_fail, 0);

      // Port stalled with two pending flows; round-robin order on release.
      tx_ready = 1'b0;
      req = 4'b0101;
      saw_send = 0;
      repeat (20) begin
         step();
         if (send_valid) saw_send = 1;
      end
      check("e_stall", saw_send, 0);
      check("e_busy", int'(busy), int'(4'b0101));
      tx_ready = 1'b1;
      req = '0;
      step();
      check_send("e_s1", 2, 0);
      step();
      check_send("e_s2", 0, 0);
      ack = 4'b0101;
      step();
      ack = '0;
      check("e_busy2", int'(busy), 0);

      // Reset while flow 2 is in flight after its third retry.
      req = 4'b0100;
      step();
      step();
      check_send("f_init", 2, 0);
      req = '0;
      for (int r = 0; r < 3; r++) begin
         wait_send(g);
         check($sformatf("f_gap%0d", r), g, gaps[r]);
      end
      repeat (5) step();
      rst = 1'b0;
      step();
      check("f_valid", int'(send_valid), 0);
      check("f_flow", int'(send_flow), 0);
      check("f_retry", int'(send_retry), 0);
      check("f_busy", int'(busy), 0);
      check("f_fail", int'(fail), 0);
      rst = 1'b1;
      saw_send = 0;
      saw_fail = 0;
      repeat (100) begin
         step();
         if (send_valid) saw_send = 1;
         if (|fail) saw_fail = 1;
      end
      check("f_quiet_send", saw_send, 0);
      check("f_quiet_fail", saw_fail, 0);

      // Round-robin pointer back at flow 0 after reset.
      req = 4'b1001;
      step();
      step();
      check_send("g_first", 0, 0);
      step();
      check_send("g_second", 3, 0);
      req = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
